// File: rtl/mux9_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux9_rr_arbiter
//
// Round-robin, burst-locking arbiter sharing one DW-bit output channel between
// nine requesters (indices 0..8). A granted requester keeps the channel until
// its last beat is accepted. The selected beat is captured in a single output
// register with valid/ready flow control.
//
// Optional feature macro: MUX9_ARB_TIMEOUT_EN
//   When defined, a grant whose owner shows no valid beat for TIMEOUT
//   consecutive cycles is forcibly released and err_timeout pulses for one
//   cycle. When undefined, the grant is held until the last beat and
//   err_timeout is constant 0.
//
// Parameters:
//   DW          data width per requester
//   TIMEOUT     idle-grant cycles before forced release (>= 1, macro only)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    [8:0]     per-requester beat valid
//   in_last     [8:0]     per-requester last-beat flag
//   in_data     [9*DW-1:0] requester k at bits [k*DW +: DW]
//   in_ready    [8:0]     per-requester accept (at most one bit set)
//   out_valid             output register holds a beat
//   out_ready             downstream accept
//   out_data    [DW-1:0]  registered beat
//   out_last              registered last flag
//   out_sel     [3:0]     current grant 0..8, 4'hF when no grant
//   err_timeout           one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mux9_rr_arbiter #(
  parameter int DW      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8:0]      in_valid,
  input  logic [8:0]      in_last,
  input  logic [9*DW-1:0] in_data,
  output logic [8:0]      in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [3:0]      out_sel,
  output logic            err_timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Elaboration-time guard on the timeout depth.
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mux9_rr_arbiter: TIMEOUT must be >= 1");
  end

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      ptr_r;
  logic [3:0]      ptr_s;
  logic [3:0]      sel_s;
  logic [3:0]      win_s;
  logic [8:0]      grant_onehot_s;
  logic            sel_valid_s;
  logic            sel_last_s;
  logic [DW-1:0]   sel_data_s;
  logic            can_take_s;
  logic            accept_s;
  logic            timeout_hit_s;

  // Pick the first requester after ptr, wrapping 8 -> 0. The scan runs from
  // the lowest-priority slot up so the last hit is the highest-priority one.
  function automatic logic [3:0] rr_pick(input logic [8:0] req,
                                         input logic [3:0] ptr);
    logic [3:0] win;
    logic [4:0] idx;
    win = 4'hF;
    for (int i = 9; i >= 1; i--) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'd9) begin
        idx = idx - 5'd9;
      end else begin
        idx = idx;
      end
      if (req[idx[3:0]]) begin
        win = idx[3:0];
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  assign win_s      = rr_pick(in_valid, ptr_r);
  // The output register can take a new beat when empty or being drained.
  assign can_take_s = !out_valid || out_ready;

  // AND-OR multiplexer selecting the granted requester's valid/last/data.
  always_comb begin
    logic hit;
    sel_valid_s    = 1'b0;
    sel_last_s     = 1'b0;
    sel_data_s     = {DW{1'b0}};
    grant_onehot_s = 9'b0;
    for (int k = 0; k < 9; k++) begin
      hit               = (out_sel == 4'(k));
      grant_onehot_s[k] = hit;
      sel_valid_s       = sel_valid_s | (in_valid[k] & hit);
      sel_last_s        = sel_last_s  | (in_last[k]  & hit);
      sel_data_s        = sel_data_s  | (in_data[k*DW +: DW] & {DW{hit}});
    end
  end

  // Next-state, grant and handshake logic for the IDLE/BUSY controller.
  always_comb begin
    state_s  = state_r;
    sel_s    = out_sel;
    ptr_s    = ptr_r;
    in_ready = 9'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|in_valid) begin
          sel_s   = win_s;
          ptr_s   = win_s;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        in_ready = grant_onehot_s & {9{can_take_s}};
        accept_s = sel_valid_s & can_take_s;
        if (accept_s && sel_last_s) begin
          state_s = IDLE;
          sel_s   = 4'hF;
        end else if (timeout_hit_s) begin
          // ptr keeps the released index so it drops to lowest priority.
          state_s = IDLE;
          sel_s   = 4'hF;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 4'hF;
      end
    endcase
  end

  // Controller state, grant pointer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 4'd8;
      out_sel   <= 4'hF;
      out_valid <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_last  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      out_sel <= sel_s;
      if (accept_s) begin
        out_valid <= 1'b1;
        out_data  <= sel_data_s;
        out_last  <= sel_last_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

`ifdef MUX9_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_r;

  // Fires on the TIMEOUT-th consecutive cycle the owner shows no valid beat.
  assign timeout_hit_s = (state_r == BUSY) && !sel_valid_s &&
                         (tmo_cnt_r == CW'(TIMEOUT - 1));

  // Idle-grant counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r   <= {CW{1'b0}};
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit_s;
      if ((state_r != BUSY) || sel_valid_s || timeout_hit_s) begin
        tmo_cnt_r <= {CW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + CW'(1);
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux9_rr_arbiter
//
// Directed bench for mux9_rr_arbiter. Per-requester source queues drive the
// inputs; every beat expected at the output is pushed to a scoreboard queue
// when it is issued, and a negedge monitor pops and compares each beat the
// DUT hands downstream. Grant/handshake/status signals are also checked
// directly against hand-computed values. Build with +define+MUX9_ARB_TIMEOUT_EN
// to exercise the timeout path instead of the held-grant path.
// -----------------------------------------------------------------------------
module tb_mux9_rr_arbiter;
  localparam int DW      = 4;
  localparam int TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [8:0]      in_valid;
  logic [8:0]      in_last;
  logic [9*DW-1:0] in_data;
  logic [8:0]      in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [3:0]      out_sel;
  logic            err_timeout;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q [$];          // {last, data}
  logic [4:0] src_mem [9][8];
  int         src_head [9];
  int         src_cnt [9];
  logic [8:0] hold;

  mux9_rr_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic redraw();
    for (int k = 0; k < 9; k++) begin
      in_valid[k] = (src_cnt[k] > 0) && !hold[k];
      {in_last[k], in_data[k*DW +: DW]} = src_mem[k][src_head[k]];
    end
  endtask

  task automatic push(input int k, input logic [3:0] d, input logic l,
                      input bit sb);
    src_mem[k][(src_head[k] + src_cnt[k]) % 8] = {l, d};
    src_cnt[k]++;
    if (sb) exp_q.push_back({l, d});
    redraw();
  endtask

  task automatic flush();
    for (int k = 0; k < 9; k++) begin
      src_head[k] = 0;
      src_cnt[k]  = 0;
    end
    hold = 9'b0;
    redraw();
  endtask

  // One clock: note handshakes before the edge, retire them after it.
  task automatic step();
    logic [8:0] hs;
    @(negedge clk);
    hs = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      if (hs[k]) begin
        src_head[k] = (src_head[k] + 1) % 8;
        src_cnt[k]--;
      end
    end
    redraw();
  endtask

  task automatic do_reset();
    check("sb_drained_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: compare every beat taken downstream.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 32'(out_data), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_beat_data", 32'(out_data), 32'(e[3:0]));
        check("sb_beat_last", 32'(out_last), 32'(e[4]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_exp [12];
    int held;
    int errs_seen;
    rr_exp = '{4'h0, 4'hF, 4'h4, 4'hF, 4'h8, 4'hF,
               4'h0, 4'hF, 4'h4, 4'hF, 4'h8, 4'hF};
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 8; j++) src_mem[k][j] = 5'b0;
    rst = 1'b1; out_ready = 1'b1; in_valid = 9'b0; in_last = 9'b0;
    in_data = '0;
    flush();
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'hF);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Single requester 3, three beats A, B, C.
    push(3, 4'hA, 1'b0, 1'b1); push(3, 4'hB, 1'b0, 1'b1); push(3, 4'hC, 1'b1, 1'b1);
    step();
    check("t1_sel_e1", 32'(out_sel), 32'd3);
    check("t1_rdy_e1", 32'(in_ready), 32'h008);
    step();
    check("t1_valid_e2", 32'(out_valid), 32'd1);
    check("t1_data_e2", 32'(out_data), 32'hA);
    check("t1_last_e2", 32'(out_last), 32'd0);
    step();
    check("t1_data_e3", 32'(out_data), 32'hB);
    check("t1_last_e3", 32'(out_last), 32'd0);
    step();
    check("t1_data_e4", 32'(out_data), 32'hC);
    check("t1_last_e4", 32'(out_last), 32'd1);
    check("t1_sel_e4", 32'(out_sel), 32'hF);
    step();
    check("t1_valid_e5", 32'(out_valid), 32'd0);

    // Round-robin wrap across 0, 4, 8.
    do_reset();
    push(0, 4'h0, 1'b1, 1'b1); push(4, 4'h4, 1'b1, 1'b1); push(8, 4'h8, 1'b1, 1'b1);
    push(0, 4'h0, 1'b1, 1'b1); push(4, 4'h4, 1'b1, 1'b1); push(8, 4'h8, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("t2_sel_e%0d", i + 1), 32'(out_sel), 32'(rr_exp[i]));
    end
    step(); step();

    // Backpressure on requester 5.
    do_reset();
    push(5, 4'h1, 1'b0, 1'b1); push(5, 4'h2, 1'b0, 1'b1);
    push(5, 4'h3, 1'b0, 1'b1); push(5, 4'h4, 1'b1, 1'b1);
    step();
    check("t3_sel_e1", 32'(out_sel), 32'd5);
    step();
    check("t3_data_e2", 32'(out_data), 32'h1);
    out_ready = 1'b0;
    #1;
    check("t3_rdy_bp", 32'(in_ready), 32'h000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t3_hold_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t3_hold_data_%0d", i), 32'(out_data), 32'h1);
      check($sformatf("t3_hold_rdy_%0d", i), 32'(in_ready), 32'h000);
    end
    out_ready = 1'b1;
    #1;
    check("t3_rdy_resume", 32'(in_ready), 32'h020);
    step(); check("t3_data_r1", 32'(out_data), 32'h2);
    step(); check("t3_data_r2", 32'(out_data), 32'h3);
    step(); check("t3_data_r3", 32'(out_data), 32'h4);
    check("t3_sel_end", 32'(out_sel), 32'hF);
    step(); check("t3_valid_end", 32'(out_valid), 32'd0);

    // Burst lock: requester 1 waits for requester 2's last beat.
    do_reset();
    push(2, 4'h5, 1'b0, 1'b1); push(2, 4'h6, 1'b0, 1'b1); push(2, 4'h7, 1'b1, 1'b1);
    step();
    check("t4_sel_e1", 32'(out_sel), 32'd2);
    push(1, 4'h9, 1'b1, 1'b1);
    check("t4_rdy_e1", 32'(in_ready), 32'h004);
    step();
    check("t4_data_e2", 32'(out_data), 32'h5);
    hold[2] = 1'b1; redraw();
    check("t4_rdy_e2", 32'(in_ready), 32'h004);
    step();
    check("t4_gap_sel", 32'(out_sel), 32'd2);
    check("t4_gap_valid", 32'(out_valid), 32'd0);
    hold[2] = 1'b0; redraw();
    step();
    check("t4_data_e4", 32'(out_data), 32'h6);
    check("t4_rdy_e4", 32'(in_ready), 32'h004);
    step();
    check("t4_sel_e5", 32'(out_sel), 32'hF);
    check("t4_rdy_e5", 32'(in_ready), 32'h000);
    step();
    check("t4_sel_e6", 32'(out_sel), 32'd1);
    check("t4_rdy_e6", 32'(in_ready), 32'h002);
    step();
    check("t4_data_e7", 32'(out_data), 32'h9);
    step();

    // Mid-burst reset: dropped beats are never expected downstream.
    out_ready = 1'b0;
    push(7, 4'h1, 1'b0, 1'b0); push(7, 4'h2, 1'b0, 1'b0); push(7, 4'h3, 1'b1, 1'b0);
    step();
    check("t4r_sel", 32'(out_sel), 32'd7);
    step();
    check("t4r_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("t4r_valid_post", 32'(out_valid), 32'd0);
    check("t4r_sel_post", 32'(out_sel), 32'hF);
    check("t4r_rdy_post", 32'(in_ready), 32'h000);
    rst = 1'b0;
    flush();
    out_ready = 1'b1;
    push(0, 4'hD, 1'b1, 1'b1); push(8, 4'hE, 1'b1, 1'b1);
    step();
    check("t4r_ptr_reset_grant", 32'(out_sel), 32'd0);
    step(); step();
    check("t4r_next_grant", 32'(out_sel), 32'd8);
    step(); step();

    // Timeout (with macro) or held grant (without).
    do_reset();
`ifdef MUX9_ARB_TIMEOUT_EN
    push(6, 4'h6, 1'b0, 1'b1); push(7, 4'h7, 1'b1, 1'b1);
    step();
    check("t5_sel_e1", 32'(out_sel), 32'd6);
    step();
    check("t5_data_e2", 32'(out_data), 32'h6);
    for (int i = 3; i <= 5; i++) begin
      step();
      check($sformatf("t5_err_e%0d", i), 32'(err_timeout), 32'd0);
      check($sformatf("t5_sel_e%0d", i), 32'(out_sel), 32'd6);
    end
    step();
    check("t5_err_pulse", 32'(err_timeout), 32'd1);
    check("t5_sel_release", 32'(out_sel), 32'hF);
    step();
    check("t5_err_end", 32'(err_timeout), 32'd0);
    check("t5_sel_next", 32'(out_sel), 32'd7);
    step();
    check("t5_data_next", 32'(out_data), 32'h7);
    step();
`else
    push(6, 4'h6, 1'b0, 1'b1); push(7, 4'h7, 1'b1, 1'b0);
    step();
    check("t5_sel_e1", 32'(out_sel), 32'd6);
    step();
    check("t5_data_e2", 32'(out_data), 32'h6);
    held = 0;
    errs_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_sel == 4'd6) held++;
      if (err_timeout) errs_seen++;
    end
    check("t5_held_cycles", 32'(held), 32'd100);
    check("t5_err_never", 32'(errs_seen), 32'd0);
    push(6, 4'hF, 1'b1, 1'b1);
    exp_q.push_back(5'h17);
    step();
    check("t5_close_sel", 32'(out_sel), 32'hF);
    step();
    check("t5_sel_next", 32'(out_sel), 32'd7);
    step(); step();
`endif

    step(); step();
    check("sb_empty_end", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux9_rr_arbiter.md
# mux9_rr_arbiter

Round-robin, burst-locking arbiter that shares one DW-bit output channel between nine requesters (indices 0..8). It sequences the 9:1 select (`out_sel`) and registers the selected beat into a single output stage with valid/ready flow control. It sits in front of the downstream consumer of the nine-way multiplexed datapath. Once a requester is granted, it keeps the channel until its `last` beat is accepted.

## Interface
- `DW`, 1, data width per requester
- `TIMEOUT`, 16, idle-grant cycles before forced release; used only with `MUX9_ARB_TIMEOUT_EN`; must be ≥ 1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  9  per-requester beat valid; bit k = requester k
- `in_last`  in  9  per-requester last-beat-of-burst flag
- `in_data`  in  9*DW  requester k occupies bits [k*DW +: DW]
- `in_ready`  out  9  per-requester accept; at most one bit set
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  downstream accept
- `out_data`  out  DW  registered beat
- `out_last`  out  1  registered last flag
- `out_sel`  out  4  current grant 0..8; 4'hF when no grant
- `err_timeout`  out  1  one-cycle pulse on forced release; tied 0 without the macro

## Operation
- FSM states: IDLE and BUSY.
- Reset values:
  - state IDLE, round-robin pointer `ptr` = 8, so requester 0 has first priority.
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_sel` = 4'hF, `in_ready` = 0, `err_timeout` = 0, timeout counter = 0.
- IDLE:
  - `in_ready` = 0.
  - If any `in_valid` is set, the winner is the first set bit scanning (ptr+1) mod 9 upward with wrap.
  - Next edge: `out_sel` ← winner, `ptr` ← winner, state ← BUSY.
  - If no `in_valid` is set, remain in IDLE.
- BUSY:
  - `in_ready[out_sel]` = !out_valid || out_ready (combinational). All other `in_ready` bits are 0.
  - Accept = `in_valid[out_sel]` && `in_ready[out_sel]`. On accept: `out_data`, `out_last` ← selected requester's data and last; `out_valid` ← 1.
  - If there is no accept and `out_ready` is high, `out_valid` ← 0.
  - Accept with `in_last[out_sel]` = 1: next state IDLE, `out_sel` ← 4'hF. The last beat stays in the output register until downstream takes it.
  - If the granted requester deasserts `in_valid` mid-burst, the grant is held.
- Output stage never overwrites an unaccepted beat. `out_valid`, `out_data`, and `out_last` are stable while out_valid && !out_ready.
- Requesters outside the grant are never acknowledged. Their `in_valid` may toggle freely.
- Reset mid-burst drops the grant and the held beat immediately. No partial-burst completion.

## Timing
- Request-to-output latency, uncontested and with `out_ready` = 1:
  - `in_valid` seen at edge 0.
  - Grant registered at edge 1.
  - First beat accepted at edge 2; `out_valid` = 1 after edge 2.
- Burst throughput: one beat per cycle while `out_ready` = 1.
- Inter-burst gap: exactly one arbitration cycle in IDLE between a last-beat accept and the next grant.
- Fairness: after requester k finishes, every other requester with continuously asserted `in_valid` is granted before k again. Worst-case wait is 8 bursts.
- Backpressure: `out_ready` low with `out_valid` = 1 forces `in_ready` to 0 in the same cycle.

## Configuration
- `MUX9_ARB_TIMEOUT_EN` defined:
  - In BUSY, a counter increments each cycle `in_valid[out_sel]` is 0 and clears on any cycle it is 1.
  - When the counter reaches `TIMEOUT`: state ← IDLE, `out_sel` ← 4'hF, counter ← 0, `err_timeout` pulses high for one cycle.
  - `ptr` keeps the released index, so that requester gets lowest priority next.
  - An already-registered output beat is still delivered.
- Not defined: no counter, `err_timeout` constant 0, grant held indefinitely until the last beat.

## Test plan
- Single requester: reset, then `in_valid[3]` = 1 for a 3-beat burst with data 0xA, 0xB, 0xC (last on 0xC) and `out_ready` = 1 → `out_sel` = 3 after edge 1. `out_data` reads 0xA, 0xB, 0xC after edges 2, 3, 4, with `out_last` only on 0xC. `out_sel` = 4'hF after edge 4.
- Round-robin wrap: requesters 0, 4, and 8 each issue continuous single-beat bursts → grant order 0, 4, 8, 0, 4, 8, with one IDLE cycle between grants.
- Backpressure: `out_ready` = 0 during a burst from requester 5 → `in_ready[5]` = 0 and `out_data` is held stable. Raising `out_ready` resumes at one beat per cycle with no lost or duplicated beats.
- Lock and mid-burst reset:
  - Requester 2 is mid-burst while requester 1 asserts `in_valid` → `in_ready[1]` stays 0 until requester 2's last beat.
  - Asserting `rst` mid-burst → after that edge `out_valid` = 0, `out_sel` = 4'hF, `ptr` = 8.
- Timeout, with the macro and `TIMEOUT` = 4: requester 6 is granted, sends one non-last beat, then drops `in_valid` → after 4 idle cycles `err_timeout` pulses for 1 cycle and `out_sel` = 4'hF. A pending requester 7 is granted next.
- Timeout disabled, without the macro: repeat the previous stimulus → grant to requester 6 is held for ≥ 100 cycles and `err_timeout` stays 0.
